// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding and helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package serial_add_ctrl_pkg;

  // FSM state encoding, kept as plain 2-bit constants so legacy consumers can match on raw values
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Supported operand width range
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Width of the bit counter for a given operand width; it only has to reach WIDTH
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a sequencer and the bit-serial adder controller.
// Latency: n/a (wires only).
// Backpressure: requests are only taken while the controller is idle; start is not queued.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Sequencer side: issues operands, watches status and result
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  // Controller side: takes operands, reports status and result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic half;

  // Propagate term shared by sum and carry
  assign half  = a ^ b;
  assign sum   = half ^ c;
  assign carry = (a & b) | (c & half);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one full_adder over WIDTH bit pairs, LSB first, carry held in a flop.
// Latency: result and done appear WIDTH cycles after the accepting edge; one addition per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests in RUN/DONE are dropped, not queued.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8  // legal range WIDTH_MIN..WIDTH_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  // One adder evaluation per RUN cycle on the current low bits and the held carry
  full_adder u_full_adder (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at sum[0]
  always_comb begin
    sum_nxt          = sum_sh >> 1;
    sum_nxt[WIDTH-1] = fa_sum;
  end

  // Controller state, operand shifters, carry flop, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            sum_sh <= '0;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_carry;
          cnt    <= cnt + CNT_ONE;
          // Last bit: publish the result on this same edge, including this cycle's sum bit
          if (cnt == CNT_LAST) begin
            sum_q  <= sum_nxt;
            cout_q <= fa_carry;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from the state register; no input-to-output path
  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
